// File: rtl/spu_regfile_mp.sv
// Multi-lane SPU issue-stage register file: per-lane writeback with same-cycle bypass,
// registered operand reads with stall-hold writeback snooping, and a busy scoreboard.
module spu_regfile_mp #(
    parameter int unsigned NUM_LANES      = 2,
    parameter int unsigned READS_PER_LANE = 3,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned ADDR_W         = 7
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        stall,
    input  logic [NUM_LANES*READS_PER_LANE*ADDR_W-1:0]  rd_addr,
    output logic [NUM_LANES*READS_PER_LANE*DATA_W-1:0]  rd_data,
    output logic [NUM_LANES*READS_PER_LANE-1:0]         rd_busy,
    input  logic [NUM_LANES-1:0]                        wb_en,
    input  logic [NUM_LANES*ADDR_W-1:0]                 wb_addr,
    input  logic [NUM_LANES*DATA_W-1:0]                 wb_data,
    input  logic [NUM_LANES-1:0]                        rsv_en,
    input  logic [NUM_LANES*ADDR_W-1:0]                 rsv_addr,
    output logic                                        wr_conflict
);

    localparam int unsigned NSLOT = NUM_LANES * READS_PER_LANE;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [ADDR_W-1:0] addr_q [NSLOT];
    logic [ADDR_W-1:0] addr_d [NSLOT];
    logic [DATA_W-1:0] data_q [NSLOT];
    logic [DATA_W-1:0] data_d [NSLOT];
    logic [NSLOT-1:0]  sbusy_q;
    logic [NSLOT-1:0]  sbusy_d;
    logic              conflict_q;
    logic              conflict_d;

    logic [ADDR_W-1:0] wb_a   [NUM_LANES];
    logic [DATA_W-1:0] wb_v   [NUM_LANES];
    logic [ADDR_W-1:0] rsv_a  [NUM_LANES];
    logic [NSLOT-1:0]  hit;
    logic [DATA_W-1:0] hit_data [NSLOT];

    // Lane buses are lane-indexed from the LSBs; read-slot buses put slot 0 in the MSBs.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            wb_a[l]  = wb_addr[l*ADDR_W +: ADDR_W];
            wb_v[l]  = wb_data[l*DATA_W +: DATA_W];
            rsv_a[l] = rsv_addr[l*ADDR_W +: ADDR_W];
        end
    end

    // Per-slot address select, bypass lookup (highest lane wins) and load/hold/refresh.
    always_comb begin
        hit     = '0;
        sbusy_d = sbusy_q;
        for (int s = 0; s < NSLOT; s++) begin
            addr_d[s]   = stall ? addr_q[s] : rd_addr[(NSLOT-1-s)*ADDR_W +: ADDR_W];
            hit_data[s] = '0;
            data_d[s]   = data_q[s];
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wb_en[l] && (wb_a[l] == addr_d[s])) begin
                    hit[s]      = 1'b1;
                    hit_data[s] = wb_v[l];
                end
            end
            if (hit[s]) begin
                data_d[s]  = hit_data[s];
                sbusy_d[s] = 1'b0;
            end else if (!stall) begin
                data_d[s]  = regs_q[addr_d[s]];
                sbusy_d[s] = busy_q[addr_d[s]];
            end
        end
    end

    // Scoreboard: clears first so a same-cycle reservation of the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wb_en[l]) begin
                busy_d[wb_a[l]] = 1'b0;
            end
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (rsv_en[l]) begin
                busy_d[rsv_a[l]] = 1'b1;
            end
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (wb_en[i] && wb_en[j] && (wb_a[i] == wb_a[j])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Array writes in ascending lane order so the highest enabled lane lands last.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            sbusy_q    <= '0;
            conflict_q <= 1'b0;
            for (int s = 0; s < NSLOT; s++) begin
                addr_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wb_en[l]) begin
                    regs_q[wb_a[l]] <= wb_v[l];
                end
            end
            busy_q     <= busy_d;
            sbusy_q    <= sbusy_d;
            conflict_q <= conflict_d;
            for (int s = 0; s < NSLOT; s++) begin
                addr_q[s] <= addr_d[s];
                data_q[s] <= data_d[s];
            end
        end
    end

    for (genvar s = 0; s < NSLOT; s++) begin : g_out
        assign rd_data[(NSLOT-1-s)*DATA_W +: DATA_W] = data_q[s];
        assign rd_busy[NSLOT-1-s]                    = sbusy_q[s];
    end

    assign wr_conflict = conflict_q;

endmodule

// File: doc/spu_regfile_mp.md
Name: spu_regfile_mp

Overview:
Parametrised multi-lane register file for the SPU issue stage, generalising the dual-issue even/odd register file. It supports NUM_LANES issue lanes with READS_PER_LANE operand reads each, and one writeback port per lane. Write-to-read bypass is same-cycle. Read data is registered with a stall-hold that snoops writebacks. A per-register busy scoreboard flags operands whose producer has not yet written back.

Parameters:
NUM_LANES, 2, issue lanes; each lane has its own read group, writeback port and reservation port.
READS_PER_LANE, 3, operand reads per lane (ra, rb, rc/rt_st).
DATA_W, 128, register width in bits.
ADDR_W, 7, register address width; depth = 2**ADDR_W.

Ports:
clock  in  1  single clock, all state on posedge.
reset  in  1  synchronous, active-low.
stall  in  1  1 = hold the registered read outputs.
rd_addr  in  NUM_LANES*READS_PER_LANE*ADDR_W  read addresses; slot s = lane*READS_PER_LANE+r, slot 0 in the MSBs.
rd_data  out  NUM_LANES*READS_PER_LANE*DATA_W  registered operand values, same slot order.
rd_busy  out  NUM_LANES*READS_PER_LANE  registered scoreboard flag per slot.
wb_en  in  NUM_LANES  writeback enable per lane.
wb_addr  in  NUM_LANES*ADDR_W  writeback destination per lane.
wb_data  in  NUM_LANES*DATA_W  writeback value per lane.
rsv_en  in  NUM_LANES  reserve destination (instruction issued) per lane.
rsv_addr  in  NUM_LANES*ADDR_W  destination being reserved.
wr_conflict  out  1  registered flag: two enabled lanes wrote the same address last cycle.

Behaviour:
- Reset (reset==0 at posedge): all 2**ADDR_W registers, all busy bits, rd_data, rd_busy and wr_conflict become 0. Reset overrides every other input that cycle.
- Write: at posedge, for each lane with wb_en=1, registers[wb_addr] <= wb_data.
- Write conflict: if several enabled lanes target the same address, the highest lane index wins, for both the array write and the bypass. wr_conflict is 1 in the following cycle only.
- Bypass value for a slot: the winning same-cycle wb_data when some wb_en lane matches rd_addr, else the array contents.
- Read latency is 1 cycle. When stall=0, the posedge loads rd_data with the bypass value for the current rd_addr.
- When stall=1, rd_addr is ignored and each slot keeps its previously latched address internally. If a same-cycle writeback matches that held address, rd_data is refreshed with the winning wb_data; otherwise it holds. Held operands therefore never go stale.
- Scoreboard, set: rsv_en sets busy[rsv_addr] at posedge.
- Scoreboard, clear: wb_en clears busy[wb_addr] at posedge.
- Scoreboard, same address same cycle: a reserve wins over a clear (a new producer has issued).
- Scoreboard, two lanes reserving one address: the bit is set; this is not an error.
- rd_busy value: busy[addr] sampled before the current cycle's updates, forced to 0 if a same-cycle writeback to addr occurs (the data is bypassed). Reservations made in the same cycle are not visible.
- rd_busy timing: it follows the same load/hold/refresh rules as rd_data. A stall-refresh from a writeback clears the held rd_busy.
- Address width: addresses wrap naturally within ADDR_W. Every address is a real register; there is no hardwired zero.
- Reset mid-stall: outputs go to 0; the held addresses are also cleared to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_en=2'b11 -> all rd_data=0, rd_busy=0, wr_conflict=0. Then release, stall=0, read slot0 at address 5 -> 0 after 1 cycle.
- Write then read: lane1 writes addr 7 = 128'hA5...A5; next cycle slot4 reads addr 7 -> rd_data slot4 = A5...A5 one cycle later. Same-cycle read of addr 7 with that write -> the bypassed value appears at the next posedge.
- Conflict: lane0 writes addr 3 = 1 and lane1 writes addr 3 = 2 in the same cycle, with slot0 reading addr 3 -> slot0 = 2, array[3] = 2, wr_conflict=1 for exactly one cycle.
- Stall snoop: latch slot2 at addr 9 (value 0), raise stall, drive rd_addr to 11, lane0 writes addr 9 = 0x55 -> slot2 becomes 0x55 and stays while stalled. The write to addr 11 has no effect on slot2.
- Scoreboard: reserve addr 20 on lane0, then read addr 20 -> rd_busy=1. Writeback addr 20 with a same-cycle read -> rd_busy=0 and data is bypassed. Reserve and writeback addr 20 in the same cycle -> busy remains 1.
- Reset mid-operation: with busy[20]=1 and stall=1, assert reset for 1 cycle -> busy cleared; reading addr 20 afterwards gives rd_busy=0, rd_data=0.
